mem_stage_access: RTL

//  MEM-stage controller on the consuming side of the EX/MEM pipeline register.

---
 rtl/mips_pipe_pkg.sv | 22 ++
 rtl/mem_wb_reg.sv | 51 +++++
 rtl/mem_stage_access.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: EX/MEM and MEM/WB control-field bit positions,
// MEM-stage FSM encoding and IO bus address width.
package mips_pipe_pkg;

  localparam int WB_REGWRITE  = 0;
  localparam int WB_MEMTOREG  = 1;

  localparam int MEM_READ     = 0;
  localparam int MEM_WRITE    = 1;
  localparam int MEM_BRANCH   = 2;
  localparam int MEM_BRANCHNE = 3;

  localparam int IO_ADDR_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2,
    S_HALT = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the control bits and the halt
// marker while the data fields keep their previous contents.
module mem_wb_reg
  import mips_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_bubble,
  input  logic [31:0] i_readdata,
  input  logic [31:0] i_result,
  input  logic [4:0]  i_wrreg,
  input  logic [1:0]  i_ctrl,
  input  logic        i_halt,
  output logic [31:0] o_readdata,
  output logic [31:0] o_result,
  output logic [4:0]  o_wrreg,
  output logic [1:0]  o_ctrl,
  output logic        o_halt
);

  logic [31:0] r_readdata, r_result;
  logic [4:0]  r_wrreg;
  logic [1:0]  r_ctrl;
  logic        r_halt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_readdata <= '0;
      r_result   <= '0;
      r_wrreg    <= '0;
      r_ctrl     <= '0;
      r_halt     <= 1'b0;
    end else begin
      r_ctrl[WB_REGWRITE] <= i_ctrl[WB_REGWRITE] & ~i_bubble;
      r_ctrl[WB_MEMTOREG] <= i_ctrl[WB_MEMTOREG] & ~i_bubble;
      r_halt              <= i_halt & ~i_bubble;
      if (!i_bubble) begin
        r_readdata <= i_readdata;
        r_result   <= i_result;
        r_wrreg    <= i_wrreg;
      end
    end
  end

  assign o_readdata = r_readdata;
  assign o_result   = r_result;
  assign o_wrreg    = r_wrreg;
  assign o_ctrl     = r_ctrl;
  assign o_halt     = r_halt;

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage controller: runs data-memory / IO req-ack transactions, stalls the
// upstream pipe while one is open, resolves branches and feeds MEM/WB.
module mem_stage_access
  import mips_pipe_pkg::*;
#(
  parameter int IO_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          ex_pc_off,
  input  logic                 ex_equal,
  input  logic [31:0]          ex_result,
  input  logic [31:0]          ex_outb,
  input  logic [4:0]           ex_wrreg,
  input  logic [1:0]           ex_wb,
  input  logic [3:0]           ex_mem,
  input  logic                 ex_ioinst,
  input  logic                 ex_halt,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [31:0]          dm_addr,
  output logic [31:0]          dm_wdata,
  input  logic [31:0]          dm_rdata,
  input  logic                 dm_ack,
  output logic                 io_req,
  output logic                 io_we,
  output logic [IO_ADDR_W-1:0] io_addr,
  output logic [31:0]          io_wdata,
  input  logic [31:0]          io_rdata,
  input  logic                 io_ack,
  output logic                 mem_stall,
  output logic                 pc_src,
  output logic [31:0]          pc_target,
  output logic                 io_timeout,
  output logic [31:0]          wb_readdata,
  output logic [31:0]          wb_result,
  output logic [4:0]           wb_wrreg,
  output logic [1:0]           wb_ctrl,
  output logic                 wb_halt
);

  mem_state_t       r_state;
  logic             r_io, r_dm_req, r_dm_we, r_io_req, r_io_we, r_tmo;
  logic [31:0]      r_addr, r_wdata, r_rdata;
  logic [CNT_W-1:0] r_cnt;

  logic             w_acc, w_ack, w_bubble;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_acc     = ex_mem[MEM_READ] | ex_mem[MEM_WRITE];
  assign w_ack     = r_io ? io_ack : dm_ack;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  // Decoded from state and acc only, so ack never reaches the stall net.
  assign mem_stall = (r_state == S_BUSY) || (r_state == S_HALT) ||
                     ((r_state == S_IDLE) && w_acc);
  assign pc_src    = (r_state != S_HALT) &&
                     ((ex_mem[MEM_BRANCH] && ex_equal) || (ex_mem[MEM_BRANCHNE] && !ex_equal));
  assign pc_target = ex_pc_off;
  assign w_bubble  = mem_stall || ((r_state == S_DONE) && r_tmo);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_io     <= 1'b0;
      r_dm_req <= 1'b0;
      r_dm_we  <= 1'b0;
      r_io_req <= 1'b0;
      r_io_we  <= 1'b0;
      r_tmo    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_state  <= S_BUSY;
            r_io     <= ex_ioinst;
            r_dm_req <= ~ex_ioinst;
            r_dm_we  <= ~ex_ioinst & ex_mem[MEM_WRITE];
            r_io_req <= ex_ioinst;
            r_io_we  <= ex_ioinst & ex_mem[MEM_WRITE];
            r_addr   <= ex_result;
            r_wdata  <= ex_outb;
            r_cnt    <= '0;
          end else if (ex_halt) begin
            r_state <= S_HALT;
          end
        end
        S_BUSY: begin
          if (w_ack) begin
            r_rdata  <= r_io ? io_rdata : dm_rdata;
            r_dm_req <= 1'b0;
            r_dm_we  <= 1'b0;
            r_io_req <= 1'b0;
            r_io_we  <= 1'b0;
            r_state  <= S_DONE;
          end else if (r_io) begin
            r_cnt <= w_cnt_nxt;
            // Abort a silent IO device; DONE then writes a bubble.
            if (w_cnt_nxt == CNT_W'(IO_TIMEOUT)) begin
              r_io_req <= 1'b0;
              r_io_we  <= 1'b0;
              r_tmo    <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign dm_req     = r_dm_req;
  assign dm_we      = r_dm_we;
  assign dm_addr    = {r_addr[31:2], 2'b00};
  assign dm_wdata   = r_wdata;
  assign io_req     = r_io_req;
  assign io_we      = r_io_we;
  assign io_addr    = r_addr[IO_ADDR_W-1:0];
  assign io_wdata   = r_wdata;
  assign io_timeout = r_tmo;

  mem_wb_reg u_mem_wb (
    .clk        (clk),
    .reset      (reset),
    .i_bubble   (w_bubble),
    .i_readdata (r_rdata),
    .i_result   (ex_result),
    .i_wrreg    (ex_wrreg),
    .i_ctrl     (ex_wb),
    .i_halt     (ex_halt),
    .o_readdata (wb_readdata),
    .o_result   (wb_result),
    .o_wrreg    (wb_wrreg),
    .o_ctrl     (wb_ctrl),
    .o_halt     (wb_halt)
  );

endmodule
